mips_fetch: RTL and testbench
=============================

# mips_fetch

Instruction-fetch stage sitting directly upstream of `mips_decode`. Holds the PC and runs a request/acknowledge handshake with instruction memory. Latches each returned word into an instruction register and splits it into the opcode/funct fields (plus rs, rt, rd, shamt, imm) that the decoder consumes. Accepts branch redirects, and stops permanently when the decoder flags an exception.

## Interface
Parameters:
- `RESET_PC`, default 32'h0040_0000: PC loaded on reset.

Ports:
- `clock` in 1: sole clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `imem_req` out 1: fetch request; high only in FETCH.
- `imem_addr` out 32: equals `pc` whenever `imem_req` is high.
- `imem_ack` in 1: memory has valid data this cycle; ignored unless `imem_req` is high.
- `imem_rdata` in 32: instruction word, valid when `imem_ack` is high.
- `inst_valid` out 1: instruction register holds an instruction awaiting issue (ISSUE state).
- `issue_ready` in 1: downstream consumes the current instruction this cycle.
- `inst` out 32: instruction register.
- `opcode` out 6, `rs` out 5, `rt` out 5, `rd` out 5, `shamt` out 5, `funct` out 6, `imm` out 16: combinational slices of `inst`: [31:26], [25:21], [20:16], [15:11], [10:6], [5:0], [15:0].
- `pc` out 32: address of the instruction in `inst` / being fetched.
- `redirect` in 1: take `redirect_pc` as the next PC instead of pc+4.
- `redirect_pc` in 32: branch/jump target.
- `decode_except` in 1: decoder `except` output for the current `opcode`/`funct`.
- `halted` out 1: sticky; the stage is in HALT.
- `fetch_except` out 1: sticky misaligned-redirect flag (see Configuration).
- `issue_count` out 32: number of instructions issued since reset.

## Operation
States:
- BOOT → FETCH unconditionally.
- FETCH:
  - `imem_req`=1.
  - When `imem_ack`=1: `inst`←`imem_rdata`, go to ISSUE.
  - Otherwise stay in FETCH; the request is held with the address stable.
- ISSUE:
  - `inst_valid`=1; `inst` and `pc` are held stable until `issue_ready`=1.
  - When `issue_ready`=1, the first matching rule applies:
    1. `decode_except`=1 → go to HALT; `pc` and `issue_count` unchanged.
    2. `redirect`=1 → `pc`←`redirect_pc`, `issue_count`+1, go to FETCH.
    3. Otherwise → `pc`←`pc`+4, `issue_count`+1, go to FETCH.
- HALT: absorbing; only `reset` exits. `halted`=1, `imem_req`=0, `inst_valid`=0; `inst` and `pc` frozen.

Reset values:
- state=BOOT, `pc`=`RESET_PC`, `inst`=0 (so all fields are 0).
- `imem_req`=0, `inst_valid`=0, `halted`=0, `fetch_except`=0, `issue_count`=0.

Boundary rules:
- `redirect` and `decode_except` are ignored outside ISSUE with `issue_ready`=1.
- `decode_except` takes priority over a simultaneous `redirect`.
- `pc`+4 and `issue_count` wrap modulo 2^32 with no flag.
- `reset` asserted mid-handshake (FETCH awaiting ack, or ISSUE awaiting ready) aborts immediately; a late `imem_ack` after reset is ignored because BOOT does not sample it.

## Timing
- Outputs are Moore: `imem_req`, `inst_valid` and `halted` decode from registered state only.
- The field outputs are combinational from `inst`; `decode_except` may therefore depend combinationally on them within the same cycle without creating a loop.
- Zero-wait memory (ack in the same cycle as req) with `issue_ready` tied high gives 2 cycles per instruction: FETCH, ISSUE, FETCH, ...
- First `imem_req` is asserted in the 2nd cycle after reset deasserts (BOOT occupies the 1st).
- Each memory wait cycle adds 1 cycle; each cycle with `issue_ready` low adds 1 cycle.
- `pc` update, `issue_count` increment and the state change all take effect on the same edge.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - An accepted redirect with `redirect_pc[1:0]`≠0 sets `fetch_except`=1 (sticky) and enters HALT.
  - `pc` keeps its old value; `issue_count` still increments (the branch itself issued).
- Undefined:
  - `fetch_except` is tied to 0.
  - An accepted redirect loads `pc`←{`redirect_pc`[31:2],2'b00}.

## Test plan
- Reset, ack tied 1, ready tied 1 → `imem_addr` = 0x00400000, 0x00400004, 0x00400008 on consecutive FETCH cycles; `inst_valid` alternates 0/1; `issue_count`=3 after the 3rd issue.
- `imem_rdata`=0x012A4020 (add $8,$9,$10) → `opcode`=0, `rs`=9, `rt`=10, `rd`=8, `funct`=0x20 during ISSUE.
- Hold `imem_ack`=0 for 4 cycles, then `issue_ready`=0 for 3 cycles → `imem_addr` stable throughout the wait; `inst`/`pc` stable throughout the stall; no count change until the ready edge.
- In ISSUE, `redirect`=1 with `redirect_pc`=0x00400100 → next `imem_addr`=0x00400100. Repeat with `decode_except`=1 also asserted → HALT, `halted`=1, `pc` unchanged, `imem_req` stays 0 for 10 cycles.
- Redirect to 0x00400102:
  - With `FETCH_ALIGN_CHECK_EN` → `fetch_except`=1, `halted`=1.
  - Without the macro → next `imem_addr`=0x00400100.
- Assert `reset` while in FETCH with a pending request, and separately at `pc`=0xFFFFFFFC → all outputs return to reset values asynchronously. Without reset, `pc`=0xFFFFFFFC wraps to 0x00000000 after the next issue.

Source files
------------

// File: rtl/mips_fetch.sv
// mips_fetch: instruction-fetch stage feeding mips_decode.
// Keeps the PC and runs a req/ack handshake with instruction memory. Each
// returned word is latched into the instruction register and presented, with
// its decoded fields, to the decoder until it is issued.
// Optional feature macro: FETCH_ALIGN_CHECK_EN. When defined, a misaligned
// redirect target sets the sticky fetch_except flag and halts the stage.
// Handshakes: imem_req/imem_ack transfers a word on any rising edge where both
// are high, and inst_valid/issue_ready issues an instruction on any rising edge
// where both are high. imem_addr and the instruction register hold steady while
// a transfer is pending.
module mips_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        issue_ready,
  output logic [31:0] inst,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm,
  output logic [31:0] pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        decode_except,
  output logic        halted,
  output logic        fetch_except,
  output logic [31:0] issue_count
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [31:0] pc_next;
  logic [31:0] inst_next;
  logic [31:0] count_next;
  logic        except_q;
  logic        except_next;

  // Next-state, next-PC and issue accounting for the fetch FSM.
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    inst_next   = inst;
    count_next  = issue_count;
    except_next = except_q;
    case (state)
      S_BOOT: state_next = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          inst_next  = imem_rdata;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (issue_ready) begin
          if (decode_except) begin
            // Faulting instruction is not counted and the PC stays on it.
            state_next = S_HALT;
          end else if (redirect) begin
            count_next = issue_count + 32'd1;
`ifdef FETCH_ALIGN_CHECK_EN
            if (redirect_pc[1:0] != 2'b00) begin
              except_next = 1'b1;
              state_next  = S_HALT;
            end else begin
              pc_next    = redirect_pc;
              state_next = S_FETCH;
            end
`else
            // Low bits are dropped so the stage always fetches a word address.
            pc_next    = redirect_pc & 32'hFFFF_FFFC;
            state_next = S_FETCH;
`endif
          end else begin
            count_next = issue_count + 32'd1;
            pc_next    = pc + 32'd4;
            state_next = S_FETCH;
          end
        end
      end
      default: state_next = S_HALT;
    endcase
  end

  // State registers; reset aborts any handshake in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_BOOT;
      pc          <= RESET_PC;
      inst        <= 32'd0;
      issue_count <= 32'd0;
      except_q    <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      inst        <= inst_next;
      issue_count <= count_next;
      except_q    <= except_next;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  assign fetch_except = except_q;
`else
  assign fetch_except = 1'b0;
`endif

  // Moore outputs decoded from the registered state only.
  assign imem_req   = (state == S_FETCH);
  assign inst_valid = (state == S_ISSUE);
  assign halted     = (state == S_HALT);
  assign imem_addr  = pc;

  // Field slices consumed by the decoder.
  assign opcode = inst[31:26];
  assign rs     = inst[25:21];
  assign rt     = inst[20:16];
  assign rd     = inst[15:11];
  assign shamt  = inst[10:6];
  assign funct  = inst[5:0];
  assign imm    = inst[15:0];

endmodule

// File: tb/tb_mips_fetch.sv
// Testbench for mips_fetch: directed and randomized instruction transactions
// compared against a transaction-level reference model.
module tb_mips_fetch;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clock;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        issue_ready;
  logic [31:0] inst;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [31:0] pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        decode_except;
  logic        halted;
  logic        fetch_except;
  logic [31:0] issue_count;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: architectural view of the stage.
  logic [31:0] m_pc;
  logic [31:0] m_count;
  logic [31:0] m_inst;
  logic        m_halted;
  logic        m_fexc;

  mips_fetch #(.RESET_PC(RST_PC)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .inst_valid(inst_valid), .issue_ready(issue_ready),
    .inst(inst), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .funct(funct), .imm(imm), .pc(pc), .redirect(redirect),
    .redirect_pc(redirect_pc), .decode_except(decode_except), .halted(halted),
    .fetch_except(fetch_except), .issue_count(issue_count)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_reset_vals();
    chk("rst_pc", pc, RST_PC);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_inst", inst, 32'd0);
    chk("rst_fields", {opcode, rs, rt, rd, shamt, funct, imm}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_fexc", {31'd0, fetch_except}, 32'd0);
    chk("rst_count", issue_count, 32'd0);
  endtask

  task automatic model_reset();
    m_pc = RST_PC;
    m_count = 0;
    m_inst = 0;
    m_halted = 0;
    m_fexc = 0;
  endtask

  // Asserts reset away from clock edges, checks reset values, releases it.
  // Returns at the negedge where the stage should first be in FETCH.
  task automatic do_reset(input logic late_ack);
    #2 reset = 1'b1;
    #1 chk_reset_vals();
    model_reset();
    imem_ack = late_ack;
    imem_rdata = $urandom;
    @(negedge clock);
    reset = 1'b0;
    chk("boot_req", {31'd0, imem_req}, 32'd0);
    @(negedge clock);
    imem_ack = 1'b0;
    chk("boot_inst", inst, 32'd0);
  endtask

  // One full fetch+issue transaction starting at a negedge in FETCH.
  task automatic run_inst(input int ack_wait, input int stall, input logic redir,
                          input logic [31:0] rpc, input logic exc,
                          input logic [31:0] word);
    chk("fetch_req", {31'd0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, m_pc);
    chk("fetch_valid", {31'd0, inst_valid}, 32'd0);
    for (int i = 0; i < ack_wait; i++) begin
      imem_ack = 1'b0;
      imem_rdata = $urandom;
      issue_ready = 1'($urandom);
      redirect = 1'($urandom);
      decode_except = 1'($urandom);
      redirect_pc = $urandom;
      @(negedge clock);
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, m_pc);
      chk("wait_count", issue_count, m_count);
    end
    imem_ack = 1'b1;
    imem_rdata = word;
    issue_ready = 1'b0;
    redirect = 1'b0;
    decode_except = 1'b0;
    @(negedge clock);
    imem_ack = 1'b0;
    m_inst = word;
    chk("issue_valid", {31'd0, inst_valid}, 32'd1);
    chk("issue_req", {31'd0, imem_req}, 32'd0);
    chk("issue_inst", inst, m_inst);
    chk("issue_opcode", {26'd0, opcode}, {26'd0, m_inst[31:26]});
    chk("issue_rs", {27'd0, rs}, {27'd0, m_inst[25:21]});
    chk("issue_rt", {27'd0, rt}, {27'd0, m_inst[20:16]});
    chk("issue_rd", {27'd0, rd}, {27'd0, m_inst[15:11]});
    chk("issue_shamt", {27'd0, shamt}, {27'd0, m_inst[10:6]});
    chk("issue_funct", {26'd0, funct}, {26'd0, m_inst[5:0]});
    chk("issue_imm", {16'd0, imm}, {16'd0, m_inst[15:0]});
    chk("issue_pc", pc, m_pc);
    for (int i = 0; i < stall; i++) begin
      issue_ready = 1'b0;
      redirect = 1'($urandom);
      decode_except = 1'($urandom);
      redirect_pc = $urandom;
      imem_ack = 1'($urandom);
      imem_rdata = $urandom;
      @(negedge clock);
      chk("stall_valid", {31'd0, inst_valid}, 32'd1);
      chk("stall_inst", inst, m_inst);
      chk("stall_pc", pc, m_pc);
      chk("stall_count", issue_count, m_count);
    end
    imem_ack = 1'b0;
    issue_ready = 1'b1;
    redirect = redir;
    redirect_pc = rpc;
    decode_except = exc;
    @(negedge clock);
    issue_ready = 1'b0;
    redirect = 1'b0;
    decode_except = 1'b0;
    if (exc) begin
      m_halted = 1'b1;
    end else begin
      m_count = m_count + 1;
      if (redir) begin
`ifdef FETCH_ALIGN_CHECK_EN
        if (rpc % 4 != 0) begin
          m_halted = 1'b1;
          m_fexc = 1'b1;
        end else begin
          m_pc = rpc;
        end
`else
        m_pc = rpc - (rpc % 4);
`endif
      end else begin
        m_pc = m_pc + 4;
      end
    end
    chk("post_halted", {31'd0, halted}, {31'd0, m_halted});
    chk("post_fexc", {31'd0, fetch_except}, {31'd0, m_fexc});
    chk("post_pc", pc, m_pc);
    chk("post_count", issue_count, m_count);
    chk("post_req", {31'd0, imem_req}, {31'd0, !m_halted});
    chk("post_valid", {31'd0, inst_valid}, 32'd0);
  endtask

  // HALT must absorb all stimulus except reset.
  task automatic hold_halt(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      imem_ack = 1'($urandom);
      imem_rdata = $urandom;
      issue_ready = 1'($urandom);
      redirect = 1'($urandom);
      redirect_pc = $urandom;
      decode_except = 1'($urandom);
      @(negedge clock);
      chk("halt_req", {31'd0, imem_req}, 32'd0);
      chk("halt_valid", {31'd0, inst_valid}, 32'd0);
      chk("halt_flag", {31'd0, halted}, 32'd1);
      chk("halt_pc", pc, m_pc);
      chk("halt_inst", inst, m_inst);
      chk("halt_count", issue_count, m_count);
    end
    imem_ack = 1'b0;
    issue_ready = 1'b0;
    redirect = 1'b0;
    decode_except = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    imem_ack = 1'b0;
    imem_rdata = 32'd0;
    issue_ready = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'd0;
    decode_except = 1'b0;
    model_reset();
    @(negedge clock);
    do_reset(1'b0);

    // Zero-wait sequential fetch; second word is add $8,$9,$10.
    run_inst(0, 0, 0, 0, 0, 32'h2108_0001);
    run_inst(0, 0, 0, 0, 0, 32'h012A_4020);
    chk("add_pc", pc, 32'h0040_0008);
    run_inst(0, 0, 0, 0, 0, $urandom);
    chk("three_issued", issue_count, 32'd3);

    // Directed field decode of add $8,$9,$10 during ISSUE.
    imem_ack = 1'b1;
    imem_rdata = 32'h012A_4020;
    @(negedge clock);
    imem_ack = 1'b0;
    chk("add_opcode", {26'd0, opcode}, 32'd0);
    chk("add_rs", {27'd0, rs}, 32'd9);
    chk("add_rt", {27'd0, rt}, 32'd10);
    chk("add_rd", {27'd0, rd}, 32'd8);
    chk("add_funct", {26'd0, funct}, 32'h20);
    issue_ready = 1'b1;
    @(negedge clock);
    issue_ready = 1'b0;
    m_pc = m_pc + 4;
    m_count = m_count + 1;
    m_inst = 32'h012A_4020;

    // Memory wait then issue stall.
    run_inst(4, 3, 0, 0, 0, $urandom);

    // Redirect, then redirect with exception (exception wins).
    run_inst(0, 0, 1, 32'h0040_0100, 0, $urandom);
    chk("redir_addr", imem_addr, 32'h0040_0100);
    run_inst(1, 1, 1, 32'h0040_0200, 1, 32'hFC00_0000);
    chk("exc_pc", pc, 32'h0040_0100);
    hold_halt(10);

    // Misaligned redirect.
    do_reset(1'b0);
    run_inst(0, 0, 1, 32'h0040_0102, 0, $urandom);
    if (m_halted) hold_halt(3);
    else chk("misalign_addr", imem_addr, 32'h0040_0100);

    // Reset while FETCH waits for ack; late ack during reset/BOOT ignored.
    do_reset(1'b0);
    run_inst(0, 0, 0, 0, 0, $urandom);
    imem_ack = 1'b0;
    @(negedge clock);
    do_reset(1'b1);
    chk("late_ack_req", {31'd0, imem_req}, 32'd1);

    // PC wrap at the top of the address space.
    run_inst(0, 0, 1, 32'hFFFF_FFFC, 0, $urandom);
    run_inst(0, 1, 0, 0, 0, $urandom);
    chk("wrap_pc", pc, 32'h0000_0000);

    // Reset while ISSUE waits for ready at pc 0xFFFFFFFC.
    run_inst(0, 0, 1, 32'hFFFF_FFFC, 0, $urandom);
    imem_ack = 1'b1;
    imem_rdata = $urandom;
    @(negedge clock);
    imem_ack = 1'b0;
    chk("pre_rst_pc", pc, 32'hFFFF_FFFC);
    do_reset(1'b0);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      logic r;
      logic [31:0] tgt;
      r = ($urandom_range(0, 3) == 0);
      tgt = $urandom;
      tgt[1:0] = 2'b00;
      run_inst($urandom_range(0, 3), $urandom_range(0, 2), r, tgt, 1'b0, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
